dsm_quant: RTL
==============

# dsm_quant

Output quantizer and loop supervisor for the 6th-order sigma-delta modulator. It sits directly downstream of the last `fac` resonator pair and consumes its 36-bit `xout` summation on every modulator sample strobe. It produces the 1-bit modulator output and the ±full-scale feedback word that drives every stage's `inpb`. It also supervises loop stability, asserting an integrator-clear request when the loop input stays overloaded.

## Interface
- `FB_POS`, default 36'sd2**32: positive feedback level; the negative level is -`FB_POS`.
- `OVL_THRESH`, default 36'sd3*2**32: overload magnitude threshold; must be < 2**35.
- `OVL_LIMIT`, default 16: number of consecutive overloaded samples that triggers a clear.
- `CLR_LEN`, default 64: length of the clear phase, in fs_enb samples.
- `DITHER_SHIFT`, default 8: left shift applied to the LFSR dither (0..19).
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset; asynchronous, active-low.
- `fs_enb`, in, 1: one-clock sample strobe, shared with the `fac` stages.
- `xsum`, in, 36: signed two's-complement loop-filter sum, from the last `fac` `xout`.
- `dither_en`, in, 1: when 1, dither is added before the sign decision.
- `dout`, out, 1: modulator bitstream.
- `fbk`, out, 36: signed feedback word, fanned out to the stages' `inpba`/`inpbb`.
- `int_clr`, out, 1: request to clear the integrators; level signal.
- `ovld`, out, 1: high while in the CLEAR state.
- `ovld_cnt`, out, 16: saturating count of CLEAR entries.

## Operation
- State machine has two states.
  - RUN: normal quantization.
  - CLEAR: recovery.
- LFSR is 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Seed 16'hACE1.
  - Advances once per fs_enb in both states, regardless of dither_en.
- Dither value `dith` = sign-extend(lfsr) <<< DITHER_SHIFT into 36 bits when dither_en=1; otherwise 0.
- RUN, on fs_enb:
  - s = xsum + dith, computed in 37 bits; no saturation.
  - dout <= ~s[36], so s ≥ 0 gives 1.
  - fbk <= dout_new ? FB_POS : -FB_POS.
- Overload test uses raw xsum, without dither.
  - Overloaded when |xsum| > OVL_THRESH.
  - xsum = 36'h8_0000_0000 always counts as overloaded.
- run_cnt:
  - Increments on each overloaded fs_enb.
  - Clears to 0 on each non-overloaded fs_enb.
  - Saturates at OVL_LIMIT.
- The fs_enb that brings run_cnt to OVL_LIMIT triggers the clear:
  - state <= CLEAR, int_clr <= 1, ovld <= 1.
  - ovld_cnt increments, saturating at 16'hFFFF.
  - clr_cnt <= CLR_LEN-1.
  - dout/fbk from that strobe are still computed normally.
- CLEAR, on each fs_enb:
  - dout toggles, first value 1, giving a zero-mean idle pattern.
  - fbk <= 0.
  - xsum is ignored for both quantization and overload.
  - clr_cnt decrements.
- The strobe that sees clr_cnt=0 performs its normal CLEAR action, then:
  - state <= RUN, int_clr <= 0, ovld <= 0, run_cnt <= 0.
  - The next strobe quantizes normally.
- Without fs_enb, all registers hold, including the LFSR.

## Timing
- All outputs are registered. They update on the clk edge where fs_enb=1, and are visible the following cycle. Latency is 1 clock.
- Reset values:
  - dout=0, fbk=0, int_clr=0, ovld=0, ovld_cnt=0.
  - state=RUN, run_cnt=0, clr_cnt=0, lfsr=16'hACE1.
- int_clr is asserted for exactly CLR_LEN strobe periods:
  - rises with the triggering strobe;
  - falls with the CLR_LEN-th CLEAR strobe.
- Back-to-back fs_enb on consecutive clocks is legal; each one is a full sample.
- Asynchronous reset mid-CLEAR drops int_clr/ovld immediately and returns to RUN. ovld_cnt is lost.

## Test plan
- Reset values: assert rst_n=0 with clk running → all outputs 0. Release reset; first fs_enb with xsum=0, dither_en=0 → dout=1, fbk=2**32.
- Sign decision and hold:
  - xsum=-1 with fs_enb → dout=0, fbk=-2**32 one cycle later.
  - Then change xsum to +5 with no fs_enb for 10 clocks → outputs unchanged.
- Threshold boundary:
  - xsum=OVL_THRESH for 100 strobes → never overloaded, int_clr stays 0.
  - xsum=36'h8_0000_0000 → counted as overloaded.
- Overload entry (OVL_LIMIT=4, CLR_LEN=8):
  - Drive 3 overloaded strobes, then 1 in-range, then 4 overloaded → CLEAR entered on the last strobe; int_clr=ovld=1, ovld_cnt=1.
  - Next 8 strobes → dout 1,0,1,0,1,0,1,0 and fbk=0.
  - Then int_clr=0 and normal quantization resumes.
- Dither (dither_en=1, xsum=0, DITHER_SHIFT=0) → dout follows ~lfsr[15] sequence starting from seed 16'hACE1; check the first 8 values against the model.
- Asynchronous reset mid-CLEAR → int_clr/ovld drop without a clock edge, ovld_cnt=0, state RUN.

Source files
------------

// File: rtl/dsm_quant.sv
// dsm_quant: output quantizer and loop supervisor for the 6th-order sigma-delta modulator.
//
// Sits after the last fac resonator pair. On every fs_enb strobe it takes the sign of the
// loop-filter sum (optionally dithered by a 16-bit LFSR) to form the 1-bit output and the
// +/-FB_POS feedback word. It also watches for a persistently overloaded loop input and,
// when that happens, runs a fixed-length clear phase that asks the integrators to reset
// while the output idles on a zero-mean 1,0,1,0 pattern.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   fs_enb     one-clock sample strobe shared with the fac stages
//   xsum       signed 36-bit loop-filter sum (last fac xout)
//   dither_en  add LFSR dither ahead of the sign decision
//   dout       modulator bitstream
//   fbk        signed feedback word for the stages' inpba/inpbb
//   int_clr    integrator-clear request (level, high for CLR_LEN strobes)
//   ovld       high while in the clear phase
//   ovld_cnt   saturating count of clear-phase entries
module dsm_quant #(
    parameter logic signed [35:0] FB_POS       = 36'sh1_0000_0000,
    parameter logic signed [35:0] OVL_THRESH   = 36'sh3_0000_0000,
    parameter int unsigned        OVL_LIMIT    = 16,
    parameter int unsigned        CLR_LEN      = 64,
    parameter int unsigned        DITHER_SHIFT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fs_enb,
    input  logic [35:0] xsum,
    input  logic        dither_en,
    output logic        dout,
    output logic [35:0] fbk,
    output logic        int_clr,
    output logic        ovld,
    output logic [15:0] ovld_cnt
);

    localparam int unsigned RunW = $clog2(OVL_LIMIT + 1);
    localparam int unsigned ClrW = (CLR_LEN > 1) ? $clog2(CLR_LEN) : 1;

    localparam logic [RunW-1:0] RunLimit = RunW'(OVL_LIMIT);
    localparam logic [ClrW-1:0] ClrInit  = ClrW'(CLR_LEN - 1);
    localparam logic [15:0]     LfsrSeed = 16'hACE1;
    localparam logic [35:0]     XsumMin  = {1'b1, 35'd0};
    localparam logic [35:0]     FbNeg    = -FB_POS;

    localparam logic StRun   = 1'b0;
    localparam logic StClear = 1'b1;

    logic            state_q, state_d;
    logic [RunW-1:0] run_cnt_q, run_cnt_d;
    logic [ClrW-1:0] clr_cnt_q, clr_cnt_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic            idle_bit_q, idle_bit_d;
    logic            dout_q, dout_d;
    logic [35:0]     fbk_q, fbk_d;
    logic            int_clr_q, int_clr_d;
    logic            ovld_q, ovld_d;
    logic [15:0]     ovld_cnt_q, ovld_cnt_d;

    logic [35:0]     lfsr_sx;
    logic [35:0]     dith;
    logic            dout_run;
    logic [35:0]     xsum_mag;
    logic            ovl_hit;
    logic            lfsr_fb;
    logic [RunW-1:0] run_cnt_inc;

    // Dither is the sign-extended LFSR word scaled up by DITHER_SHIFT.
    always_comb begin
        lfsr_sx = {{20{lfsr_q[15]}}, lfsr_q};
        dith    = dither_en ? (lfsr_sx << DITHER_SHIFT) : 36'd0;
    end

    // Sign of the 37-bit sum; the extra bit means xsum + dith can never wrap.
    always_comb begin
        dout_run = ($signed({xsum[35], xsum}) + $signed({dith[35], dith})) >= 37'sd0;
    end

    // The most negative xsum has no positive magnitude in 36 bits, so it is
    // flagged explicitly rather than trusting the wrapped negation.
    always_comb begin
        xsum_mag = xsum[35] ? (~xsum + 36'd1) : xsum;
        ovl_hit  = (xsum == XsumMin) || (xsum_mag > $unsigned(OVL_THRESH));
    end

    // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1.
    always_comb begin
        lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    end

    always_comb begin
        run_cnt_inc = (run_cnt_q == RunLimit) ? run_cnt_q : run_cnt_q + RunW'(1);
    end

    always_comb begin
        state_d    = state_q;
        run_cnt_d  = run_cnt_q;
        clr_cnt_d  = clr_cnt_q;
        lfsr_d     = lfsr_q;
        idle_bit_d = idle_bit_q;
        dout_d     = dout_q;
        fbk_d      = fbk_q;
        int_clr_d  = int_clr_q;
        ovld_d     = ovld_q;
        ovld_cnt_d = ovld_cnt_q;

        if (fs_enb) begin
            lfsr_d = {lfsr_q[14:0], lfsr_fb};

            if (state_q == StRun) begin
                dout_d    = dout_run;
                fbk_d     = dout_run ? FB_POS : FbNeg;
                run_cnt_d = ovl_hit ? run_cnt_inc : '0;

                if (ovl_hit && (run_cnt_inc == RunLimit)) begin
                    state_d    = StClear;
                    int_clr_d  = 1'b1;
                    ovld_d     = 1'b1;
                    clr_cnt_d  = ClrInit;
                    idle_bit_d = 1'b1;
                    ovld_cnt_d = (ovld_cnt_q == 16'hFFFF) ? ovld_cnt_q : ovld_cnt_q + 16'd1;
                end
            end else begin
                // Idle pattern keeps the output zero-mean while the loop is cleared.
                dout_d     = idle_bit_q;
                idle_bit_d = ~idle_bit_q;
                fbk_d      = '0;

                if (clr_cnt_q == '0) begin
                    state_d   = StRun;
                    int_clr_d = 1'b0;
                    ovld_d    = 1'b0;
                    run_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q - ClrW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            run_cnt_q  <= '0;
            clr_cnt_q  <= '0;
            lfsr_q     <= LfsrSeed;
            idle_bit_q <= 1'b0;
            dout_q     <= 1'b0;
            fbk_q      <= '0;
            int_clr_q  <= 1'b0;
            ovld_q     <= 1'b0;
            ovld_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            run_cnt_q  <= run_cnt_d;
            clr_cnt_q  <= clr_cnt_d;
            lfsr_q     <= lfsr_d;
            idle_bit_q <= idle_bit_d;
            dout_q     <= dout_d;
            fbk_q      <= fbk_d;
            int_clr_q  <= int_clr_d;
            ovld_q     <= ovld_d;
            ovld_cnt_q <= ovld_cnt_d;
        end
    end

    assign dout     = dout_q;
    assign fbk      = fbk_q;
    assign int_clr  = int_clr_q;
    assign ovld     = ovld_q;
    assign ovld_cnt = ovld_cnt_q;

endmodule
